// File: rtl/cello_tt_pkg.sv
// Shared types and sizes for the Cello truth-table sweeper.
// Pure declarations; no latency or flow control of its own.
package cello_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int N_ROWS = 8;
  localparam int ROW_W  = 3;
  localparam int TT_W   = 8;

endpackage

// File: rtl/tt_sync.sv
// Reset-to-0 flop chain bringing the possibly-asynchronous gate output into clk.
// Latency: SYNC_STAGES cycles; free-running, no backpressure.
module tt_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_bit,
  output logic sync_bit
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain[0] <= async_bit;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign sync_bit = chain[SYNC_STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input gate through rows 000..111 and captures its truth table (row 000 = MSB).
// Latency 8*(SETTLE_CYCLES+SYNC_STAGES+1)+1 cycles start-to-done; start ignored while busy, abort cancels.
module truth_table_sweeper
  import cello_tt_pkg::*;
#(
  parameter int              SETTLE_CYCLES = 4,
  parameter int              SYNC_STAGES   = 2,
  parameter logic [TT_W-1:0] EXPECTED      = 8'h2C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            gate_out,
  output logic            in1,
  output logic            in2,
  output logic            in3,
  output logic            busy,
  output logic            done,
  output logic [TT_W-1:0] result,
  output logic            match
);

  localparam int WAIT_SPAN = SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_W     = ($clog2(WAIT_SPAN + 1) < 1) ? 1 : $clog2(WAIT_SPAN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_SPAN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

  state_t            state, state_nxt;
  logic [ROW_W-1:0]  row, row_nxt;
  logic [CNT_W-1:0]  wait_cnt, cnt_nxt;
  logic [TT_W-1:0]   result_nxt;
  logic [TT_W-1:0]   shifted;
  logic              match_nxt;
  logic              gate_sync;

  tt_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_bit (gate_out),
    .sync_bit  (gate_sync)
  );

  assign shifted = {result[TT_W-2:0], gate_sync};

  // The row register is the gate drive itself, so the gate inputs are glitch-free flops.
  assign {in1, in2, in3} = row;

  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    cnt_nxt    = wait_cnt;
    result_nxt = result;
    match_nxt  = match;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt  = WAIT;
          row_nxt    = '0;
          cnt_nxt    = '0;
          result_nxt = '0;
          match_nxt  = 1'b0;
        end
      end

      WAIT: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt  = IDLE;
          row_nxt    = '0;
          cnt_nxt    = '0;
          result_nxt = '0;
          match_nxt  = 1'b0;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end

      SAMPLE: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt  = IDLE;
          row_nxt    = '0;
          cnt_nxt    = '0;
          result_nxt = '0;
          match_nxt  = 1'b0;
        end else begin
          result_nxt = shifted;
          cnt_nxt    = '0;
          if (row == ROW_LAST) begin
            // Match is registered with the final shift so it is already valid while done pulses.
            state_nxt = FINISH;
            row_nxt   = '0;
            match_nxt = (shifted == EXPECTED);
          end else begin
            state_nxt = WAIT;
            row_nxt   = row + ROW_W'(1);
          end
        end
      end

      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        row_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      row      <= '0;
      wait_cnt <= '0;
      result   <= '0;
      match    <= 1'b0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      wait_cnt <= cnt_nxt;
      result   <= result_nxt;
      match    <= match_nxt;
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (default timing and SETTLE=0/SYNC=1) driving reference gates.
module tb_truth_table_sweeper;

  typedef struct {
    logic [7:0] res;
    logic       m;
    logic       exact;
    int         acc;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, abort_a, start_b, abort_b;
  logic gate_a, gate_b;
  logic in1_a, in2_a, in3_a, busy_a, done_a, match_a;
  logic in1_b, in2_b, in3_b, busy_b, done_b, match_b;
  logic [7:0] result_a, result_b;
  logic [2:0] row_a, row_b;
  logic [7:0] func_a = 8'h2C;
  logic [7:0] func_b = 8'h2C;
  logic       dly_mode_b = 1'b0;
  logic [2:0] dly_b = 3'b000;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  logic       prev_busy [2] = '{1'b0, 1'b0};
  logic [2:0] last_row  [2] = '{3'd0, 3'd0};
  logic       seq_ok    [2] = '{1'b0, 1'b0};
  int         nrows     [2] = '{0, 0};
  logic       chk_m     [2] = '{1'b0, 1'b0};
  logic       exp_m     [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign row_a = {in1_a, in2_a, in3_a};
  assign row_b = {in1_b, in2_b, in3_b};

  // Reference gates: truth-table word F, row r answers with bit (7-r).
  assign gate_a = func_a[3'd7 - row_a];
  always @(posedge clk) dly_b <= {dly_b[1:0], func_b[3'd7 - row_b]};
  assign gate_b = dly_mode_b ? dly_b[2] : func_b[3'd7 - row_b];

  truth_table_sweeper dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_a),
    .abort    (abort_a),
    .gate_out (gate_a),
    .in1      (in1_a),
    .in2      (in2_a),
    .in3      (in3_a),
    .busy     (busy_a),
    .done     (done_a),
    .result   (result_a),
    .match    (match_a)
  );

  truth_table_sweeper #(
    .SETTLE_CYCLES (0),
    .SYNC_STAGES   (1),
    .EXPECTED      (8'h2C)
  ) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_b),
    .abort    (abort_b),
    .gate_out (gate_b),
    .in1      (in1_b),
    .in2      (in2_b),
    .in3      (in3_b),
    .busy     (busy_b),
    .done     (done_b),
    .result   (result_b),
    .match    (match_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? sb_a.size() : sb_b.size();
  endfunction

  // Monitor: follows row order while busy, pops the scoreboard on done, checks match a cycle later.
  task automatic mon(input int d, input logic done, input logic busy, input logic [2:0] row,
                     input logic [7:0] result, input logic match);
    exp_t e;
    if (busy && !prev_busy[d]) begin
      last_row[d] = row;
      nrows[d]    = 1;
      seq_ok[d]   = (row == 3'd0);
    end else if (busy && row != last_row[d]) begin
      if (row != last_row[d] + 3'd1) seq_ok[d] = 1'b0;
      last_row[d] = row;
      nrows[d]++;
    end
    prev_busy[d] = busy;

    if (done) begin
      if (qsize(d) == 0) begin
        check("spurious_done", 32'(done), 32'd0);
      end else begin
        e = (d == 0) ? sb_a.pop_front() : sb_b.pop_front();
        check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        if (e.exact) check("result", 32'(result), 32'(e.res));
        else         check("result_differs", 32'(result != e.res), 32'd1);
        check("rows_in_order", 32'(seq_ok[d] && nrows[d] == 8), 32'd1);
        chk_m[d] = 1'b1;
        exp_m[d] = e.m;
      end
    end else if (chk_m[d]) begin
      check("match", 32'(match), 32'(exp_m[d]));
      chk_m[d] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, done_a, busy_a, row_a, result_a, match_a);
    mon(1, done_b, busy_b, row_b, result_b, match_b);
  end

  // Issue one start pulse to an idle sweeper and record what the finished sweep must show.
  task automatic kick(input int d, input logic [7:0] f, input logic exact);
    exp_t e;
    @(posedge clk); #1;
    if (d == 0) begin func_a = f; start_a = 1'b1; end
    else        begin func_b = f; start_b = 1'b1; end
    e.res   = f;
    e.m     = exact ? (f == 8'h2C) : 1'b0;
    e.exact = exact;
    e.acc   = cyc + 1;
    e.lat   = (d == 0) ? 8 * (4 + 2 + 1) + 1 : 8 * (0 + 1 + 1) + 1;
    if (d == 0) sb_a.push_back(e); else sb_b.push_back(e);
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while ((qsize(d) != 0 || chk_m[d]) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(qsize(d)), 32'd0);
    if (d == 0) sb_a.delete(); else sb_b.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic abort_after(input int n);
    repeat (n) @(posedge clk);
    #1 abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    void'(sb_a.pop_back());
    check("abort_busy",   32'(busy_a),   32'd0);
    check("abort_rows",   32'(row_a),    32'd0);
    check("abort_result", 32'(result_a), 32'd0);
    check("abort_match",  32'(match_a),  32'd0);
    repeat (70) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   32'(busy_a),   32'd0);
    check("reset_done",   32'(done_a),   32'd0);
    check("reset_rows",   32'(row_a),    32'd0);
    check("reset_result", 32'(result_a), 32'd0);
    check("reset_match",  32'(match_a),  32'd0);
    check("reset_b",      32'({busy_b, done_b, row_b, result_b, match_b}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reference 0x2C gate, then constant-0 and constant-1 gates.
    kick(0, 8'h2C, 1'b1); drain(0);
    kick(0, 8'h00, 1'b1); drain(0);
    kick(0, 8'hFF, 1'b1); drain(0);

    // Random gate functions.
    for (int i = 0; i < 6; i++) begin
      f = 8'($urandom);
      kick(0, f, 1'b1);
      drain(0);
    end

    // start re-pulsed in cycle 10 of a sweep is ignored.
    kick(0, 8'h2C, 1'b1);
    repeat (8) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    drain(0);

    // Abort in cycle 20, then at random points, each followed by a fresh sweep.
    kick(0, 8'h2C, 1'b1); abort_after(18);
    kick(0, 8'h2C, 1'b1); drain(0);
    for (int i = 0; i < 3; i++) begin
      kick(0, 8'($urandom), 1'b1);
      abort_after(int'($urandom_range(0, 50)));
    end

    // start and abort together in IDLE: abort wins.
    @(posedge clk); #1;
    start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; abort_a = 1'b0;
    check("start_abort_idle", 32'(busy_a), 32'd0);
    repeat (70) @(posedge clk);

    // abort during the FINISH cycle does not stop the sweep.
    kick(0, 8'h96, 1'b1);
    repeat (56) @(posedge clk);
    #1 abort_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0;
    drain(0);

    // Asynchronous reset in cycle 30 of a sweep.
    kick(0, 8'h2C, 1'b1);
    repeat (28) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(busy_a),   32'd0);
    check("arst_rows",   32'(row_a),    32'd0);
    check("arst_result", 32'(result_a), 32'd0);
    check("arst_match",  32'(match_a),  32'd0);
    sb_a.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    kick(0, 8'h2C, 1'b1); drain(0);

    // Fast sweeper: 17-cycle sweep, then a gate slower than the settle window.
    kick(1, 8'h2C, 1'b1); drain(1);
    f = 8'($urandom);
    kick(1, f, 1'b1); drain(1);
    func_b = 8'h2C;
    dly_mode_b = 1'b1;
    repeat (6) @(posedge clk);
    kick(1, 8'h2C, 1'b0); drain(1);
    dly_mode_b = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
